// File: rtl/hot_page_dedup_fifo.sv
// Hot-page PFN candidate buffer: drops all-ones and recently-seen PFNs, then
// queues the survivors in a FIFO feeding the HAPB pusher's page_mig_addr port.
module hot_page_dedup_fifo #(
  parameter int ADDR_SIZE  = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          axi4_mm_clk,
  input  logic                          axi4_mm_rst_n,
  input  logic                          hot_pg_valid,
  input  logic [ADDR_SIZE-1:0]          hot_pg_addr,
  output logic                          hot_pg_ready,
  output logic                          page_mig_addr_en,
  output logic [ADDR_SIZE-1:0]          page_mig_addr,
  input  logic                          page_mig_addr_ready,
  input  logic                          csr_dedup_en,
  input  logic                          csr_hist_flush,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   dup_drop_cnt,
  output logic [31:0]                   inv_drop_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HPTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [HPTR_W-1:0] HPTR_LAST = HPTR_W'(HIST_DEPTH - 1);

  logic [ADDR_SIZE-1:0] fifo_mem  [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] hist_addr [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [HPTR_W-1:0]    hist_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 init_done;

  logic accept_p0;
  logic inv_p0;
  logic hit_p0;
  logic dup_p0;
  logic push_p0;
  logic pop_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Accept-cycle classification: invalid beats duplicate beats push
  always_comb begin
    hit_p0 = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_vld[i] && (hist_addr[i] == hot_pg_addr)) hit_p0 = 1'b1;
    end
  end

  // Ready is held low for the first cycle after reset release and whenever full;
  // it never looks at page_mig_addr_ready, so the pusher has no path back to the tracker.
  assign hot_pg_ready     = init_done && (fifo_count != FULL_CNT);
  assign accept_p0        = hot_pg_valid && hot_pg_ready;
  assign inv_p0           = accept_p0 && (&hot_pg_addr);
  assign dup_p0           = accept_p0 && !inv_p0 && csr_dedup_en && hit_p0;
  assign push_p0          = accept_p0 && !inv_p0 && !dup_p0;

  assign page_mig_addr_en = (fifo_count != '0);
  assign pop_p0           = page_mig_addr_en && page_mig_addr_ready;
  assign page_mig_addr    = page_mig_addr_en ? fifo_mem[rd_ptr] : '0;

  // Storage arrays carry no reset; occupancy and valid bits qualify them
  always_ff @(posedge axi4_mm_clk) begin
    if (push_p0) begin
      fifo_mem[wr_ptr]    <= hot_pg_addr;
      hist_addr[hist_ptr] <= hot_pg_addr;
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      init_done    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      hist_vld     <= '0;
      hist_ptr     <= '0;
      dup_drop_cnt <= '0;
      inv_drop_cnt <= '0;
    end else begin
      init_done <= 1'b1;
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_p0 && !pop_p0)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push_p0 && pop_p0) fifo_count <= fifo_count - CNT_W'(1);

      // A flush coinciding with a push keeps only the entry written this cycle
      if (csr_hist_flush) hist_vld <= '0;
      if (push_p0) begin
        hist_vld[hist_ptr] <= 1'b1;
        hist_ptr <= (hist_ptr == HPTR_LAST) ? '0 : hist_ptr + HPTR_W'(1);
      end

      if (inv_p0) inv_drop_cnt <= sat_inc(inv_drop_cnt);
      if (dup_p0) dup_drop_cnt <= sat_inc(dup_drop_cnt);
    end
  end

endmodule
